// File: rtl/snac_joy_reader.sv
// SNAC/DB15 serial joystick reader: clocks chained pad shift registers, debounces each
// bit per frame and muxes SNAC or USB per player. Optional combo outputs: SNAC_COMBO_EN.
module snac_joy_reader #(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned BITS            = 12,
  parameter int unsigned CLK_DIV         = 256,
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_PLAYERS-1:0]      snac_en,
  input  logic [NUM_PLAYERS*BITS-1:0] usb_joy,
  input  logic                        JOY_DATA,
  output logic                        JOY_CLK,
  output logic                        JOY_LOAD,
  output logic [NUM_PLAYERS*BITS-1:0] joy_out,
  output logic [NUM_PLAYERS*BITS-1:0] snac_raw,
`ifdef SNAC_COMBO_EN
  output logic [NUM_PLAYERS-1:0]      pause_req,
  output logic [NUM_PLAYERS-1:0]      service_req,
`endif
  output logic                        frame_valid
);

  localparam int unsigned Total = NUM_PLAYERS * BITS;
  localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW  = $clog2(Total + 1);
  localparam logic [2:0]  DbLast = 3'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StCommit} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [1:0]              sync_q;
  logic [Total-1:0]        sr_q;
  logic [Total-1:0]        frame;
  logic [Total-1:0]        raw_q, raw_d;
  logic [Total-1:0][2:0]   dbc_q, dbc_d;
  logic                    frame_valid_q;
  logic                    tick;
  logic                    commit_now;

  assign tick       = (cnt_q == CntW'(CLK_DIV - 1));
  assign commit_now = (state_q == StHigh) && tick && (bit_q == BitW'(Total - 1));

  // Synchroniser idles high so an absent pad reads as released.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], JOY_DATA};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q         <= '0;
      state_q       <= StIdle;
      bit_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      cnt_q         <= tick ? '0 : cnt_q + CntW'(1);
      state_q       <= state_d;
      bit_q         <= bit_d;
      frame_valid_q <= commit_now;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    JOY_CLK  = 1'b0;
    JOY_LOAD = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StLoad;
      end
      StLoad: begin
        JOY_LOAD = 1'b1;
        if (tick) begin
          state_d = StLow;
          bit_d   = '0;
        end
      end
      StLow: begin
        if (tick) state_d = StHigh;
      end
      StHigh: begin
        JOY_CLK = 1'b1;
        if (tick) begin
          if (bit_q == BitW'(Total - 1)) begin
            state_d = StCommit;
          end else begin
            bit_d   = bit_q + BitW'(1);
            state_d = StLow;
          end
        end
      end
      StCommit: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sample on the final cycle of LOW; pad data is active-low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sr_q <= '0;
    end else if ((state_q == StLow) && tick) begin
      sr_q <= {sr_q[Total-2:0], ~sync_q[1]};
    end
  end

  // Samples arrive player 0 first, MSB first, so only the player order is reversed.
  always_comb begin
    frame = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      for (int unsigned b = 0; b < BITS; b++) begin
        frame[p*BITS + b] = sr_q[(NUM_PLAYERS - 1 - p)*BITS + b];
      end
    end
  end

  always_comb begin
    raw_d = raw_q;
    dbc_d = dbc_q;
    if (commit_now) begin
      for (int unsigned i = 0; i < Total; i++) begin
        if (frame[i] == raw_q[i]) begin
          dbc_d[i] = 3'd0;
        end else if (dbc_q[i] == DbLast) begin
          raw_d[i] = frame[i];
          dbc_d[i] = 3'd0;
        end else begin
          dbc_d[i] = dbc_q[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      raw_q <= '0;
      dbc_q <= '0;
    end else begin
      raw_q <= raw_d;
      dbc_q <= dbc_d;
    end
  end

  assign snac_raw    = raw_q;
  assign frame_valid = frame_valid_q;

`ifdef SNAC_COMBO_EN
  logic [NUM_PLAYERS-1:0] pause_q, service_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pause_q   <= '0;
      service_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        pause_q[p]   <= snac_en[p] & raw_q[p*BITS + 11] & raw_q[p*BITS + 4];
        service_q[p] <= snac_en[p] & raw_q[p*BITS + 11] & raw_q[p*BITS + 5];
      end
    end
  end

  assign pause_req   = pause_q;
  assign service_req = service_q;
`endif

  always_comb begin
    joy_out = usb_joy;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (snac_en[p]) joy_out[p*BITS +: BITS] = raw_q[p*BITS +: BITS];
`ifdef SNAC_COMBO_EN
      // Combo buttons are consumed by the combo and hidden from the core.
      if (pause_q[p] || service_q[p]) begin
        joy_out[p*BITS + 11] = 1'b0;
        joy_out[p*BITS + 4]  = 1'b0;
        joy_out[p*BITS + 5]  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_snac_joy_reader.sv
// Directed bench for snac_joy_reader: two instances (debounce 1 and 3) share one pad model.
module tb_snac_joy_reader;

  localparam int NP    = 2;
  localparam int B     = 12;
  localparam int CD    = 4;
  localparam int FRAME = (2 * NP * B + 3) * CD;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     snac_en;
  logic [NP*B-1:0]   usb_joy;
  logic              joy_data;
  logic              joy_clk, joy_load, frame_valid;
  logic [NP*B-1:0]   joy_out, snac_raw;
  logic              joy_clk3, joy_load3, frame_valid3;
  logic [NP*B-1:0]   joy_out3, snac_raw3;

  int checks = 0;
  int errors = 0;

  logic [B-1:0]    pad_p0, pad_p1;
  logic [NP*B-1:0] pad_sh = '0;
  logic            pad_prev = 1'b0;
  logic            nopad;

  always #5 clk = ~clk;

  // Chained pads: player 0 MSB appears first, active-low on the wire.
  always @(posedge clk) begin
    pad_prev <= joy_clk;
    if (joy_load) pad_sh <= {pad_p0, pad_p1};
    else if (joy_clk && !pad_prev) pad_sh <= {pad_sh[NP*B-2:0], 1'b0};
  end
  assign joy_data = nopad ? 1'b1 : ~pad_sh[NP*B-1];

  snac_joy_reader #(.NUM_PLAYERS(NP), .BITS(B), .CLK_DIV(CD), .DEBOUNCE_FRAMES(1)) dut (
    .clk_sys(clk), .reset(reset), .snac_en(snac_en), .usb_joy(usb_joy), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk), .JOY_LOAD(joy_load), .joy_out(joy_out), .snac_raw(snac_raw),
    .frame_valid(frame_valid)
  );

  snac_joy_reader #(.NUM_PLAYERS(NP), .BITS(B), .CLK_DIV(CD), .DEBOUNCE_FRAMES(3)) dut3 (
    .clk_sys(clk), .reset(reset), .snac_en(snac_en), .usb_joy(usb_joy), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk3), .JOY_LOAD(joy_load3), .joy_out(joy_out3), .snac_raw(snac_raw3),
    .frame_valid(frame_valid3)
  );

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_valid && n < 2000);
    if (!frame_valid) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_valid after %0d cycles, required within 2000", n);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    snac_en = 2'b01;
    usb_joy = {12'h00F, 12'h123};
    nopad   = 1'b0;
    pad_p0  = 12'hA5C;
    pad_p1  = 12'h3F1;
    repeat (3) @(negedge clk);
    checks++; if (joy_clk !== 1'b0) begin errors++;
      $display("FAIL reset_joy_clk: got %b want 0", joy_clk); end
    checks++; if (joy_load !== 1'b0) begin errors++;
      $display("FAIL reset_joy_load: got %b want 0", joy_load); end
    checks++; if (frame_valid !== 1'b0) begin errors++;
      $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    checks++; if (snac_raw !== 24'h0) begin errors++;
      $display("FAIL reset_snac_raw: got %h want 000000", snac_raw); end
    checks++; if (joy_out !== {12'h00F, 12'h000}) begin errors++;
      $display("FAIL reset_joy_out: got %h want 00f000", joy_out); end
    reset = 1'b0;
  endtask

  task automatic test_frame();
    int n = 0, loads = 0, clkhi = 0;
    wait_frame();
    checks++; if (snac_raw !== {12'h3F1, 12'hA5C}) begin errors++;
      $display("FAIL frame_data: got %h want 3f1a5c", snac_raw); end
    do begin
      @(negedge clk);
      n++;
      if (joy_load) loads++;
      if (joy_clk) clkhi++;
      if (n == 1) begin
        checks++; if (frame_valid !== 1'b0) begin errors++;
          $display("FAIL frame_valid_width: got %b one cycle after pulse, want 0", frame_valid);
        end
      end
    end while (!frame_valid && n < 2000);
    checks++; if (n != FRAME) begin errors++;
      $display("FAIL frame_length: got %0d cycles want %0d", n, FRAME); end
    checks++; if (loads != CD) begin errors++;
      $display("FAIL load_width: got %0d cycles want %0d", loads, CD); end
    checks++; if (clkhi != NP * B * CD) begin errors++;
      $display("FAIL clk_high_cycles: got %0d want %0d", clkhi, NP * B * CD); end
    checks++; if (snac_raw3 !== 24'h0) begin errors++;
      $display("FAIL debounce3_frame2: got %h want 000000", snac_raw3); end
  endtask

  task automatic test_debounce();
    wait_frame();
    checks++; if (snac_raw3 !== {12'h3F1, 12'hA5C}) begin errors++;
      $display("FAIL debounce3_frame3: got %h want 3f1a5c", snac_raw3); end
    pad_p0 = 12'hA5D;
    wait_frame();
    checks++; if (snac_raw[0] !== 1'b1) begin errors++;
      $display("FAIL debounce1_rise: got %b want 1", snac_raw[0]); end
    checks++; if (snac_raw3[0] !== 1'b0) begin errors++;
      $display("FAIL debounce3_glitch1: got %b want 0", snac_raw3[0]); end
    wait_frame();
    checks++; if (snac_raw3[0] !== 1'b0) begin errors++;
      $display("FAIL debounce3_glitch2: got %b want 0", snac_raw3[0]); end
    pad_p0 = 12'hA5C;
    wait_frame();
    checks++; if (snac_raw3[0] !== 1'b0) begin errors++;
      $display("FAIL debounce3_release: got %b want 0", snac_raw3[0]); end
    pad_p0 = 12'hA5D;
    for (int f = 1; f <= 3; f++) begin
      wait_frame();
      checks++; if (snac_raw3[0] !== (f == 3)) begin errors++;
        $display("FAIL debounce3_hold%0d: got %b want %b", f, snac_raw3[0], (f == 3)); end
    end
    pad_p0 = 12'hA5C;
    wait_frame();
  endtask

  task automatic test_mux();
    pad_p1 = 12'hFFF;
    wait_frame();
    snac_en = 2'b01;
    usb_joy = {12'h00F, 12'h123};
    #1;
    checks++; if (joy_out !== {12'h00F, 12'hA5C}) begin errors++;
      $display("FAIL mux_usb_p1: got %h want 00fa5c", joy_out); end
    usb_joy = {12'h0F0, 12'h123};
    #1;
    checks++; if (joy_out[23:12] !== 12'h0F0) begin errors++;
      $display("FAIL mux_usb_passthru: got %h want 0f0", joy_out[23:12]); end
    snac_en = 2'b11;
    #1;
    checks++; if (joy_out !== {12'hFFF, 12'hA5C}) begin errors++;
      $display("FAIL mux_snac_both: got %h want fffa5c", joy_out); end
    snac_en = 2'b10;
    #1;
    checks++; if (joy_out !== {12'hFFF, 12'h123}) begin errors++;
      $display("FAIL mux_snac_p1_only: got %h want fff123", joy_out); end
  endtask

  task automatic test_reset_mid();
    int h = 0, n = 0;
    logic prev = 1'b0;
    pad_p1 = 12'h3F1;
    wait_frame();
    do begin
      @(negedge clk);
      n++;
      if (joy_clk && !prev) h++;
      prev = joy_clk;
    end while (!(h == 9 && !joy_clk) && n < 2000);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (joy_clk !== 1'b0 || joy_load !== 1'b0) begin errors++;
      $display("FAIL midreset_pins: got clk=%b load=%b want 0 0", joy_clk, joy_load); end
    checks++; if (snac_raw !== 24'h0) begin errors++;
      $display("FAIL midreset_raw: got %h want 000000", snac_raw); end
    reset = 1'b0;
    n = 0;
    while (!frame_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != FRAME - CD) begin errors++;
      $display("FAIL midreset_restart: frame_valid after %0d cycles want %0d", n, FRAME - CD); end
    checks++; if (snac_raw !== {12'h3F1, 12'hA5C}) begin errors++;
      $display("FAIL midreset_data: got %h want 3f1a5c", snac_raw); end
  endtask

  task automatic test_no_pad();
    int pulses = 0;
    wait_frame();
    nopad   = 1'b1;
    snac_en = 2'b11;
    for (int n = 0; n < 5 * FRAME; n++) begin
      @(negedge clk);
      if (frame_valid) pulses++;
    end
    checks++; if (pulses != 5) begin errors++;
      $display("FAIL nopad_pulses: got %0d want 5", pulses); end
    checks++; if (snac_raw !== 24'h0) begin errors++;
      $display("FAIL nopad_raw: got %h want 000000", snac_raw); end
    checks++; if (joy_out !== 24'h0) begin errors++;
      $display("FAIL nopad_joy_out: got %h want 000000", joy_out); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_debounce();
    test_mux();
    test_reset_mid();
    test_no_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
